// File: rtl/dcache_ecc_mem_bank.sv
// Flop-based ECC cache-line bank for one way, with per-byte write enables and a
// fault-injection port that flips one stored codeword bit while the port is idle.
module dcache_ecc_mem_bank #(
  parameter int NUM_WORDS  = 256,
  parameter int DATA_BYTES = 16,
  parameter int TAG_BYTES  = 6,
  parameter int AW         = $clog2(NUM_WORDS),
  parameter int BW         = $clog2(DATA_BYTES*13)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [AW-1:0]            addr_i,
  input  logic [DATA_BYTES*13-1:0] wdata_data_i,
  input  logic [TAG_BYTES*13-1:0]  wdata_tag_i,
  input  logic                     wdata_valid_i,
  input  logic                     wdata_dirty_i,
  input  logic [DATA_BYTES-1:0]    be_data_i,
  input  logic [TAG_BYTES-1:0]     be_tag_i,
  input  logic                     be_vldrty_i,
  output logic [DATA_BYTES*13-1:0] rdata_data_o,
  output logic [TAG_BYTES*13-1:0]  rdata_tag_o,
  output logic                     rdata_valid_o,
  output logic                     rdata_dirty_o,
  input  logic                     inj_req_i,
  input  logic [AW-1:0]            inj_addr_i,
  input  logic                     inj_field_i,
  input  logic [BW-1:0]            inj_bit_i,
  output logic                     inj_busy_o,
  output logic                     inj_done_o,
  output logic                     inj_err_o,
  output logic [15:0]              inj_count_o
);

  localparam int DW = DATA_BYTES*13;
  localparam int TW = TAG_BYTES*13;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} inj_state_e;

  logic [DW-1:0] mem_data_q  [NUM_WORDS];
  logic [DW-1:0] mem_data_d  [NUM_WORDS];
  logic [TW-1:0] mem_tag_q   [NUM_WORDS];
  logic [TW-1:0] mem_tag_d   [NUM_WORDS];
  logic [NUM_WORDS-1:0] mem_valid_q, mem_valid_d;
  logic [NUM_WORDS-1:0] mem_dirty_q, mem_dirty_d;

  logic [DW-1:0] rdata_data_q, rdata_data_d;
  logic [TW-1:0] rdata_tag_q, rdata_tag_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          rdata_dirty_q, rdata_dirty_d;

  inj_state_e    state_q, state_d;
  logic [AW-1:0] inj_addr_q, inj_addr_d;
  logic          inj_field_q, inj_field_d;
  logic [BW-1:0] inj_bit_q, inj_bit_d;
  logic          inj_err_q, inj_err_d;
  logic [15:0]   inj_count_q, inj_count_d;

  logic do_flip;
  logic bit_in_range;

  // The flip fires on the WAIT->DONE edge, which only happens with the port idle.
  assign do_flip      = (state_q == S_WAIT) && !req_i;
  assign bit_in_range = inj_field_q ? (int'(inj_bit_q) < TW) : (int'(inj_bit_q) < DW);

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (inj_req_i) state_d = S_WAIT;
      S_WAIT:  if (!req_i)    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    inj_busy_o = (state_q == S_WAIT);
    inj_done_o = (state_q == S_DONE);
    inj_err_o  = (state_q == S_DONE) && inj_err_q;
  end

  always_comb begin
    inj_addr_d  = inj_addr_q;
    inj_field_d = inj_field_q;
    inj_bit_d   = inj_bit_q;
    inj_err_d   = inj_err_q;
    inj_count_d = inj_count_q;
    if (state_q == S_IDLE && inj_req_i) begin
      inj_addr_d  = inj_addr_i;
      inj_field_d = inj_field_i;
      inj_bit_d   = inj_bit_i;
    end
    if (do_flip) begin
      inj_err_d = !bit_in_range;
      if (bit_in_range && inj_count_q != 16'hFFFF) inj_count_d = inj_count_q + 16'd1;
    end
  end

  always_comb begin
    mem_data_d  = mem_data_q;
    mem_tag_d   = mem_tag_q;
    mem_valid_d = mem_valid_q;
    mem_dirty_d = mem_dirty_q;
    if (req_i && we_i) begin
      for (int k = 0; k < DATA_BYTES; k++)
        if (be_data_i[k]) mem_data_d[addr_i][13*k +: 13] = wdata_data_i[13*k +: 13];
      for (int k = 0; k < TAG_BYTES; k++)
        if (be_tag_i[k]) mem_tag_d[addr_i][13*k +: 13] = wdata_tag_i[13*k +: 13];
      if (be_vldrty_i) begin
        mem_valid_d[addr_i] = wdata_valid_i;
        mem_dirty_d[addr_i] = wdata_dirty_i;
      end
    end
    // Shifted one-hot mask keeps the bit index free of field-width truncation.
    if (do_flip && bit_in_range) begin
      if (inj_field_q) mem_tag_d[inj_addr_q]  = mem_tag_q[inj_addr_q]  ^ (TW'(1) << inj_bit_q);
      else             mem_data_d[inj_addr_q] = mem_data_q[inj_addr_q] ^ (DW'(1) << inj_bit_q);
    end
  end

  always_comb begin
    rdata_data_d  = rdata_data_q;
    rdata_tag_d   = rdata_tag_q;
    rdata_valid_d = rdata_valid_q;
    rdata_dirty_d = rdata_dirty_q;
    if (req_i && !we_i) begin
      rdata_data_d  = mem_data_q[addr_i];
      rdata_tag_d   = mem_tag_q[addr_i];
      rdata_valid_d = mem_valid_q[addr_i];
      rdata_dirty_d = mem_dirty_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        mem_data_q[w] <= '0;
        mem_tag_q[w]  <= '0;
      end
      mem_valid_q   <= '0;
      mem_dirty_q   <= '0;
      rdata_data_q  <= '0;
      rdata_tag_q   <= '0;
      rdata_valid_q <= 1'b0;
      rdata_dirty_q <= 1'b0;
      inj_addr_q    <= '0;
      inj_field_q   <= 1'b0;
      inj_bit_q     <= '0;
      inj_err_q     <= 1'b0;
      inj_count_q   <= '0;
    end else begin
      mem_data_q    <= mem_data_d;
      mem_tag_q     <= mem_tag_d;
      mem_valid_q   <= mem_valid_d;
      mem_dirty_q   <= mem_dirty_d;
      rdata_data_q  <= rdata_data_d;
      rdata_tag_q   <= rdata_tag_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_dirty_q <= rdata_dirty_d;
      inj_addr_q    <= inj_addr_d;
      inj_field_q   <= inj_field_d;
      inj_bit_q     <= inj_bit_d;
      inj_err_q     <= inj_err_d;
      inj_count_q   <= inj_count_d;
    end
  end

  assign rdata_data_o  = rdata_data_q;
  assign rdata_tag_o   = rdata_tag_q;
  assign rdata_valid_o = rdata_valid_q;
  assign rdata_dirty_o = rdata_dirty_q;
  assign inj_count_o   = inj_count_q;

endmodule
